// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC encoder front end: default window geometry,
// derived widths and the LBP encoder state type.
package hdc_pkg;

    // Default window geometry.
    localparam int DEF_NUM_CHS     = 2;
    localparam int DEF_WINDOW_SIZE = 4;
    localparam int DEF_SAMPLE_SIZE = 2;
    localparam int DEF_LBP_LEN     = 2;

    // Number of codes one channel produces from one window.
    function automatic int calc_ncode(input int window_size, input int lbp_len);
        return window_size - lbp_len;
    endfunction

    // Width of an index counting 0..n-1; never narrower than one bit.
    function automatic int calc_min1_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the channel index carried alongside each code.
    function automatic int calc_ch_w(input int num_chs);
        return calc_min1_w(num_chs);
    endfunction

    // Width of the time-position index carried alongside each code.
    function automatic int calc_idx_w(input int ncode);
        return calc_min1_w(ncode);
    endfunction

    // IDLE waits for a window; RUN streams its codes out.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lbp_state_e;

endpackage : hdc_pkg

// File: rtl/lbp_code_gen.sv
// Combinational LBP code generator: LBP_LEN+1 consecutive samples of one
// channel in (index 0 = oldest), one LBP_LEN-bit code out. Bit k is set when
// the sample after position k is strictly greater, signed.
module lbp_code_gen
    import hdc_pkg::*;
#(
    parameter int SAMPLE_SIZE = DEF_SAMPLE_SIZE,
    parameter int LBP_LEN     = DEF_LBP_LEN
) (
    input  logic [LBP_LEN:0][SAMPLE_SIZE-1:0] samples_i,
    output logic [LBP_LEN-1:0]                code_o
);

    // One signed greater-than per code bit; equal neighbours give 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        code_o = '0;
        for (int k = 0; k < LBP_LEN; k++) begin
            code_o[k] = ($signed(samples_i[k+1]) > $signed(samples_i[k]));
        end
    end

endmodule : lbp_code_gen

// File: rtl/lbp_encoder.sv
// LBP encoder: captures a completed sliding window and streams one LBP code
// per (time position, channel) over a valid/ready handshake, time-major and
// channel-minor. Windows arriving while a stream is in progress are dropped
// and flagged on the sticky overrun output.
module lbp_encoder
    import hdc_pkg::*;
#(
    parameter int  NUM_CHS     = DEF_NUM_CHS,
    parameter int  WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int  SAMPLE_SIZE = DEF_SAMPLE_SIZE,
    parameter int  LBP_LEN     = DEF_LBP_LEN,
    localparam int NCODE       = calc_ncode(WINDOW_SIZE, LBP_LEN),
    localparam int CH_W        = calc_ch_w(NUM_CHS),
    localparam int IDX_W       = calc_idx_w(NCODE),
    localparam int WIN_W       = WINDOW_SIZE * NUM_CHS * SAMPLE_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               win_valid,
    input  logic [WIN_W-1:0]   win_data,
    output logic               win_ready,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [LBP_LEN-1:0] code_data,
    output logic [CH_W-1:0]    code_ch,
    output logic [IDX_W-1:0]   code_idx,
    output logic               code_last,
    output logic               overrun
);

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCODE - 1);

    // Window buffer laid out exactly like win_data: [time][channel][bit].
    typedef logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] win_buf_t;

    lbp_state_e         state_q, state_d;
    win_buf_t           buf_q, buf_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               code_valid_q, code_valid_d;
    logic [LBP_LEN-1:0] code_data_q, code_data_d;
    logic               code_last_q, code_last_d;
    logic               win_ready_q, win_ready_d;
    logic               overrun_q, overrun_d;

    // Control strobes from the sequencing logic to the code register.
    logic               load_code;
    logic               clear_code;

    // Samples feeding the code generator and its result.
    logic [LBP_LEN:0][SAMPLE_SIZE-1:0] gen_samples;
    logic [LBP_LEN-1:0]                gen_code;

    // Sequencing: capture, pointer stepping, exit to IDLE and overrun tracking.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        ch_d         = ch_q;
        idx_d        = idx_q;
        code_valid_d = code_valid_q;
        code_last_d  = code_last_q;
        win_ready_d  = win_ready_q;
        overrun_d    = overrun_q;
        load_code    = 1'b0;
        clear_code   = 1'b0;

        unique case (state_q)
            IDLE: begin
                win_ready_d = 1'b1;
                if (win_valid) begin
                    buf_d        = win_data;
                    ch_d         = '0;
                    idx_d        = '0;
                    state_d      = RUN;
                    win_ready_d  = 1'b0;
                    code_valid_d = 1'b1;
                    load_code    = 1'b1;
                end
            end

            RUN: begin
                // Any window offered while busy is lost, including on the
                // cycle of the final handshake.
                if (win_valid) begin
                    overrun_d = 1'b1;
                end
                if (code_valid_q && code_ready) begin
                    if (code_last_q) begin
                        state_d      = IDLE;
                        code_valid_d = 1'b0;
                        win_ready_d  = 1'b1;
                        ch_d         = '0;
                        idx_d        = '0;
                        code_last_d  = 1'b0;
                        clear_code   = 1'b1;
                    end else begin
                        if (ch_q == LAST_CH) begin
                            ch_d  = '0;
                            idx_d = idx_q + 1'b1;
                        end else begin
                            ch_d  = ch_q + 1'b1;
                        end
                        load_code = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_code) begin
            code_last_d = (idx_d == LAST_IDX) && (ch_d == LAST_CH);
        end
    end

    // Select LBP_LEN+1 consecutive samples of channel ch_d starting at idx_d
    // from the window the next code will come from (the incoming one on capture).
    always_comb begin
        gen_samples = '0;
        for (int k = 0; k <= LBP_LEN; k++) begin
            for (int t = 0; t < NCODE; t++) begin
                for (int c = 0; c < NUM_CHS; c++) begin
                    if ((idx_d == IDX_W'(t)) && (ch_d == CH_W'(c))) begin
                        gen_samples[k] = buf_d[t+k][c];
                    end
                end
            end
        end
    end

    lbp_code_gen #(
        .SAMPLE_SIZE (SAMPLE_SIZE),
        .LBP_LEN     (LBP_LEN)
    ) u_code_gen (
        .samples_i (gen_samples),
        .code_o    (gen_code)
    );

    // Code register: take the newly selected code, clear on exit, else hold.
    always_comb begin
        code_data_d = code_data_q;
        if (load_code) begin
            code_data_d = gen_code;
        end else if (clear_code) begin
            code_data_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q      <= IDLE;
            // NOTE: the window buffer is tiny and is cleared on reset so an
            // aborted window can never resurface; large memories would not be.
            buf_q        <= '0;
            ch_q         <= '0;
            idx_q        <= '0;
            code_valid_q <= 1'b0;
            code_data_q  <= '0;
            code_last_q  <= 1'b0;
            win_ready_q  <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            ch_q         <= ch_d;
            idx_q        <= idx_d;
            code_valid_q <= code_valid_d;
            code_data_q  <= code_data_d;
            code_last_q  <= code_last_d;
            win_ready_q  <= win_ready_d;
            overrun_q    <= overrun_d;
        end
    end

    assign win_ready  = win_ready_q;
    assign code_valid = code_valid_q;
    assign code_data  = code_data_q;
    assign code_ch    = ch_q;
    assign code_idx   = idx_q;
    assign code_last  = code_last_q;
    assign overrun    = overrun_q;

endmodule : lbp_encoder

// File: tb/tb_lbp_encoder.sv
// Self-checking bench for lbp_encoder: directed windows from the test plan plus
// randomized windows, backpressure and overrun pulses, all compared against a
// queue of expected codes computed from signed sample arithmetic.
`timescale 1ns/1ps
module tb_lbp_encoder;
    import hdc_pkg::*;

    localparam int NUM_CHS     = DEF_NUM_CHS;
    localparam int WINDOW_SIZE = DEF_WINDOW_SIZE;
    localparam int SAMPLE_SIZE = DEF_SAMPLE_SIZE;
    localparam int LBP_LEN     = DEF_LBP_LEN;
    localparam int NCODE       = WINDOW_SIZE - LBP_LEN;
    localparam int NTOT        = NUM_CHS * NCODE;
    localparam int CH_W        = (NUM_CHS > 1) ? $clog2(NUM_CHS) : 1;
    localparam int IDX_W       = (NCODE > 1) ? $clog2(NCODE) : 1;
    localparam int WIN_W       = WINDOW_SIZE * NUM_CHS * SAMPLE_SIZE;

    typedef struct {
        int idx;
        int ch;
        int code;
        int last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               win_valid = 1'b0;
    logic [WIN_W-1:0]   win_data = '0;
    logic               win_ready;
    logic               code_valid;
    logic               code_ready = 1'b0;
    logic [LBP_LEN-1:0] code_data;
    logic [CH_W-1:0]    code_ch;
    logic [IDX_W-1:0]   code_idx;
    logic               code_last;
    logic               overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ovr  = 0;
    int   last_cycles = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lbp_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_ready  (win_ready),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .code_ch    (code_ch),
        .code_idx   (code_idx),
        .code_last  (code_last),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Signed value of sample (t, c) of a packed window.
    function automatic int sample_val(input logic [WIN_W-1:0] w, input int t, input int c);
        int raw;
        raw = int'(w[(t*NUM_CHS + c)*SAMPLE_SIZE +: SAMPLE_SIZE]);
        return (raw >= (1 << (SAMPLE_SIZE-1))) ? raw - (1 << SAMPLE_SIZE) : raw;
    endfunction

    // Reference: list every code of a window in time-major, channel-minor order.
    task automatic build_expected(input logic [WIN_W-1:0] w);
        exp_t e;
        exp_q.delete();
        for (int t = 0; t < NCODE; t++) begin
            for (int c = 0; c < NUM_CHS; c++) begin
                e.idx  = t;
                e.ch   = c;
                e.code = 0;
                for (int k = 0; k < LBP_LEN; k++) begin
                    if (sample_val(w, t+k+1, c) > sample_val(w, t+k, c)) begin
                        e.code += (1 << k);
                    end
                end
                e.last = (t == NCODE-1 && c == NUM_CHS-1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [WIN_W-1:0] rand_window();
        logic [WIN_W-1:0] w;
        for (int i = 0; i < WIN_W; i++) begin
            w[i] = 1'($urandom_range(0, 1));
        end
        return w;
    endfunction

    // Same sample sequence on every channel; seq[0] is the oldest sample.
    function automatic logic [WIN_W-1:0] same_all_ch(input logic [SAMPLE_SIZE-1:0] seq[WINDOW_SIZE]);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int t = 0; t < WINDOW_SIZE; t++) begin
            for (int c = 0; c < NUM_CHS; c++) begin
                w[(t*NUM_CHS + c)*SAMPLE_SIZE +: SAMPLE_SIZE] = seq[t];
            end
        end
        return w;
    endfunction

    // Offer window w (called on a falling edge, block idle) and consume its codes.
    // mode 0: ready high, 1: ready toggling starting low, 2: random ready.
    // ovr_at >= 0 pulses win_valid with junk on that stream cycle.
    // abort_after >= 0 asserts rst once that many codes were accepted.
    task automatic run_window(input string name, input logic [WIN_W-1:0] w,
                              input int mode, input int ovr_at, input int abort_after);
        int cyc;
        int n_hs;
        bit r;
        bit aborted;
        cyc = 0;
        n_hs = 0;
        aborted = 1'b0;
        build_expected(w);
        win_valid = 1'b1;
        win_data  = w;
        code_ready = 1'b0;
        @(negedge clk);
        win_valid = 1'b0;
        check({name, "/first_valid"}, int'(code_valid), 1);
        check({name, "/busy"}, int'(win_ready), 0);
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (code_valid) begin
                check({name, "/idx"},  int'(code_idx),  exp_q[0].idx);
                check({name, "/ch"},   int'(code_ch),   exp_q[0].ch);
                check({name, "/code"}, int'(code_data), exp_q[0].code);
                check({name, "/last"}, int'(code_last), exp_q[0].last);
            end else begin
                check({name, "/valid_during_stream"}, int'(code_valid), 1);
            end
            code_ready = r;
            if (cyc == ovr_at) begin
                win_valid = 1'b1;
                win_data  = rand_window();
                exp_ovr   = 1;
            end else begin
                win_valid = 1'b0;
            end
            if (r && code_valid) begin
                exp_q.delete(0);
                n_hs++;
            end
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && n_hs == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        win_valid  = 1'b0;
        code_ready = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_ovr = 0;
            check({name, "/abort_valid"},   int'(code_valid), 0);
            check({name, "/abort_ready"},   int'(win_ready),  1);
            check({name, "/abort_overrun"}, int'(overrun),    0);
            check({name, "/abort_ch"},      int'(code_ch),    0);
            check({name, "/abort_idx"},     int'(code_idx),   0);
            exp_q.delete();
        end else begin
            check({name, "/codes_left"}, exp_q.size(), 0);
            check({name, "/done_valid"}, int'(code_valid), 0);
            check({name, "/done_ready"}, int'(win_ready), 1);
            check({name, "/overrun"}, int'(overrun), exp_ovr);
        end
        last_cycles = cyc;
    endtask

    // Block must stay idle: no codes, ready for a window.
    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            check({name, "/idle_valid"}, int'(code_valid), 0);
            check({name, "/idle_ready"}, int'(win_ready), 1);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [SAMPLE_SIZE-1:0] basic_seq[WINDOW_SIZE];
        logic [SAMPLE_SIZE-1:0] flat_seq[WINDOW_SIZE];
        logic [WIN_W-1:0]       basic_win;
        basic_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        flat_seq  = '{2'b00, 2'b00, 2'b00, 2'b00};
        basic_win = same_all_ch(basic_seq);

        // Reset held two cycles with a window offered: nothing captured.
        rst        = 1'b1;
        win_valid  = 1'b1;
        win_data   = rand_window();
        code_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        win_valid = 1'b0;
        code_ready = 1'b0;
        check("reset/win_ready",  int'(win_ready),  1);
        check("reset/code_valid", int'(code_valid), 0);
        check("reset/overrun",    int'(overrun),    0);
        check("reset/code_data",  int'(code_data),  0);
        check("reset/code_last",  int'(code_last),  0);
        idle_check("reset", 1);

        // Basic window at full throughput; codes 10,10,11,11.
        run_window("basic", basic_win, 0, -1, -1);
        check("basic/cycles", last_cycles, NTOT);

        // Same window with ready toggling: identical sequence in 2x cycles.
        run_window("bp", basic_win, 1, -1, -1);
        check("bp/cycles", last_cycles, 2 * NTOT);

        // Flat samples: equality gives zero bits.
        run_window("flat", same_all_ch(flat_seq), 0, -1, -1);

        // Overrun two cycles after capture; stream unaffected, flag sticky.
        run_window("ovr", basic_win, 0, 1, -1);
        idle_check("ovr", 3);
        run_window("after_ovr", rand_window(), 0, -1, -1);

        // Reset after the second accepted code, then a fresh window from (0,0).
        run_window("abort", basic_win, 0, -1, 2);
        idle_check("abort", 2);
        run_window("after_abort", basic_win, 0, -1, -1);

        // Window offered on the cycle of the final handshake is dropped.
        run_window("ovr_last", rand_window(), 0, NTOT - 1, -1);
        idle_check("ovr_last", 2);

        // Randomized windows, ready and overrun pulses.
        for (int i = 0; i < 25; i++) begin
            int ovr;
            ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NTOT)) : -1;
            run_window("rand", rand_window(), 2, ovr, -1);
            if ($urandom_range(0, 1) == 1) begin
                idle_check("rand", 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_lbp_encoder
